// File: rtl/hwregs.sv
// hwregs: memory-mapped board registers (LEDs, seven-segment, switches),
// an optional free-running cycle timer and a FIFO-fed 8N1 UART transmitter.
// Read responses are registered and arrive one cycle after the request,
// carrying the request tag.
// Build option: define HWREGS_TIMER_EN to include the TIMER register at 0x20.
module hwregs #(
  parameter int unsigned CLOCK_HZ      = 100000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned TX_FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hwregs_request,
  input  logic        hwregs_write,
  input  logic [15:0] hwregs_addr,
  input  logic [3:0]  hwregs_wmask,
  input  logic [31:0] hwregs_wdata,
  output logic        hwregs_rvalid,
  output logic [8:0]  hwregs_rtag,
  output logic [31:0] hwregs_rdata,
  input  logic [9:0]  switches,
  output logic [9:0]  leds,
  output logic [23:0] seven_seg,
  output logic        uart_tx
);

  localparam int unsigned Div      = CLOCK_HZ / BAUD;
  localparam int unsigned CntW     = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned PtrW     = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned FifoCntW = PtrW + 1;

  localparam logic [13:0] AddrSevenSeg = 14'h00;
  localparam logic [13:0] AddrLeds     = 14'h01;
  localparam logic [13:0] AddrSwitches = 14'h02;
  localparam logic [13:0] AddrUartTx   = 14'h04;
  localparam logic [13:0] AddrUartStat = 14'h05;
`ifdef HWREGS_TIMER_EN
  localparam logic [13:0] AddrTimer    = 14'h08;
`endif

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [13:0] word;
  logic        wr_en, rd_en;
  logic        unused_addr;

  assign word        = hwregs_addr[15:2];
  assign wr_en       = hwregs_request & hwregs_write;
  assign rd_en       = hwregs_request & ~hwregs_write;
  assign unused_addr = ^hwregs_addr[1:0];

  // LED and seven-segment registers with byte-enable writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      seven_seg <= '0;
      leds      <= '0;
    end else if (wr_en) begin
      if (word == AddrSevenSeg) begin
        for (int b = 0; b < 3; b++) begin
          if (hwregs_wmask[b]) seven_seg[b*8 +: 8] <= hwregs_wdata[b*8 +: 8];
        end
      end
      if (word == AddrLeds) begin
        if (hwregs_wmask[0]) leds[7:0] <= hwregs_wdata[7:0];
        if (hwregs_wmask[1]) leds[9:8] <= hwregs_wdata[9:8];
      end
    end
  end

  // TX FIFO storage and bookkeeping.
  logic [7:0]          fifo_mem [TX_FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FifoCntW-1:0] count_q;
  logic                overflow_q;
  logic                fifo_full, fifo_empty, push_req, push, pop;
  logic [15:0]         free_slots;

  assign fifo_full  = (count_q == FifoCntW'(TX_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push_req   = wr_en & (word == AddrUartTx) & hwregs_wmask[0];
  // Fullness is judged before any same-cycle pop, so a push at full is lost.
  assign push       = push_req & ~fifo_full;
  assign free_slots = 16'(TX_FIFO_DEPTH) - 16'(count_q);

  // FIFO data array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= hwregs_wdata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_req && fifo_full) overflow_q <= 1'b1;
      else if (rd_en && word == AddrUartTx) overflow_q <= 1'b0;
    end
  end

  // UART serializer.
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            baud_end, busy;

  assign baud_end = (cnt_q == CntW'(Div - 1));
  assign busy     = ~fifo_empty | (state_q != StIdle);

  // Serializer state register; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  // Serializer next state, FIFO pop and line level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    uart_tx = 1'b1;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_mem[rd_ptr_q];
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        uart_tx = 1'b0;
        if (baud_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        uart_tx = data_q[bit_q];
        if (baud_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef HWREGS_TIMER_EN
  logic [31:0] timer_q;

  // Free-running cycle counter; any write to TIMER restarts it from zero.
  always_ff @(posedge clock) begin
    if (reset)                            timer_q <= '0;
    else if (wr_en && word == AddrTimer)  timer_q <= '0;
    else                                  timer_q <= timer_q + 1'b1;
  end
`endif

  logic [31:0] rd_data;

  // Read data mux on the request-cycle address.
  always_comb begin
    rd_data = 32'hDEADBEEF;
    case (word)
      AddrSevenSeg: rd_data = {8'h00, seven_seg};
      AddrLeds:     rd_data = {22'h0, leds};
      AddrSwitches: rd_data = {22'h0, switches};
      AddrUartTx:   rd_data = {overflow_q, 15'h0, free_slots};
      AddrUartStat: rd_data = {31'h0, busy};
`ifdef HWREGS_TIMER_EN
      AddrTimer:    rd_data = timer_q;
`endif
      default:      rd_data = 32'hDEADBEEF;
    endcase
  end

  // Registered read response; data and tag hold between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      hwregs_rvalid <= 1'b0;
      hwregs_rtag   <= '0;
      hwregs_rdata  <= '0;
    end else begin
      hwregs_rvalid <= rd_en;
      if (rd_en) begin
        hwregs_rtag  <= hwregs_wdata[8:0];
        hwregs_rdata <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_hwregs.sv
// Directed bench for hwregs: a register vector table plus hand-written
// sequences for UART framing, FIFO overflow, timer and mid-frame reset.
// Runs with divider 4 (CLOCK_HZ 400, BAUD 100) and a 16-entry FIFO.
module tb_hwregs;

  logic        clock = 1'b0;
  logic        reset;
  logic        request, write;
  logic [15:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        rvalid;
  logic [8:0]  rtag;
  logic [31:0] rdata;
  logic [9:0]  switches;
  logic [9:0]  leds;
  logic [23:0] seven_seg;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hwregs #(
    .CLOCK_HZ     (400),
    .BAUD         (100),
    .TX_FIFO_DEPTH(16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .hwregs_request(request),
    .hwregs_write  (write),
    .hwregs_addr   (addr),
    .hwregs_wmask  (wmask),
    .hwregs_wdata  (wdata),
    .hwregs_rvalid (rvalid),
    .hwregs_rtag   (rtag),
    .hwregs_rdata  (rdata),
    .switches      (switches),
    .leds          (leds),
    .seven_seg     (seven_seg),
    .uart_tx       (uart_tx)
  );

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [3:0]  m;
    logic [31:0] d;    // write data, or tag in [8:0] for reads
    logic [31:0] exp;  // expected read data
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [3:0] m, input logic [31:0] d);
    request = 1'b1; write = 1'b1; addr = a; wmask = m; wdata = d;
    @(posedge clock);
    #1;
    request = 1'b0; write = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [8:0] tag,
                            input logic [31:0] exp);
    request = 1'b1; write = 1'b0; addr = a; wmask = 4'h0; wdata = {23'h0, tag};
    @(posedge clock);
    #1;
    request = 1'b0;
    check({name, "_rvalid"}, 64'(rvalid), 64'd1);
    check({name, "_rdata"}, 64'(rdata), 64'(exp));
    check({name, "_rtag"}, 64'(rtag), 64'(tag));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] got, expv;
    logic [7:0]  byte_v;
    int          n, lows;

    vecs[0]  = '{1'b1, 16'h0004, 4'b0001, 32'h0000_03FF, 32'h0};
    vecs[1]  = '{1'b0, 16'h0004, 4'b0000, 32'h0000_01A5, 32'h0000_00FF};
    vecs[2]  = '{1'b1, 16'h0004, 4'b0010, 32'h0000_0300, 32'h0};
    vecs[3]  = '{1'b0, 16'h0004, 4'b0000, 32'h0000_0002, 32'h0000_03FF};
    vecs[4]  = '{1'b1, 16'h0000, 4'b0101, 32'hAABB_CCDD, 32'h0};
    vecs[5]  = '{1'b0, 16'h0000, 4'b0000, 32'h0000_00FF, 32'h00BB_00DD};
    vecs[6]  = '{1'b1, 16'h0000, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[7]  = '{1'b0, 16'h0000, 4'b0000, 32'h0000_0004, 32'h0034_5678};
    vecs[8]  = '{1'b0, 16'h0008, 4'b0000, 32'h0000_0005, 32'h0000_02A5};
    vecs[9]  = '{1'b1, 16'h0008, 4'b1111, 32'h0000_0000, 32'h0};
    vecs[10] = '{1'b0, 16'h0008, 4'b0000, 32'h0000_0006, 32'h0000_02A5};
    vecs[11] = '{1'b0, 16'h0100, 4'b0000, 32'h0000_0003, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 16'h0010, 4'b0000, 32'h0000_0007, 32'h0000_0010};
    vecs[13] = '{1'b0, 16'h0014, 4'b0000, 32'h0000_0008, 32'h0000_0000};
    vecs[14] = '{1'b1, 16'h000C, 4'b1111, 32'h0000_0001, 32'h0};
    vecs[15] = '{1'b0, 16'h000C, 4'b0000, 32'h0000_0009, 32'hDEAD_BEEF};
    vecs[16] = '{1'b0, 16'h0006, 4'b0000, 32'h0000_000A, 32'h0000_03FF};
    vecs[17] = '{1'b1, 16'h0000, 4'b0000, 32'hFFFF_FFFF, 32'h0};
    vecs[18] = '{1'b0, 16'h0003, 4'b0000, 32'h0000_000B, 32'h0034_5678};
    vecs[19] = '{1'b1, 16'h0004, 4'b0001, 32'h0000_005A, 32'h0};
    vecs[20] = '{1'b0, 16'h0004, 4'b0000, 32'h0000_01FF, 32'h0000_035A};

    switches = 10'h2A5;
    // Reset with a read request held high: the request must be ignored.
    reset = 1'b1; request = 1'b1; write = 1'b0; addr = 16'h0004; wmask = 4'h0;
    wdata = 32'h0000_001F;
    repeat (3) idle_cycle();
    check("reset_rvalid", 64'(rvalid), 64'd0);
    check("reset_rtag", 64'(rtag), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_leds", 64'(leds), 64'd0);
    check("reset_seven_seg", 64'(seven_seg), 64'd0);
    check("reset_uart_tx", 64'(uart_tx), 64'd1);
    request = 1'b0; reset = 1'b0;
    idle_cycle();
    check("post_reset_rvalid", 64'(rvalid), 64'd0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].a, vecs[i].m, vecs[i].d);
        check($sformatf("vec%0d_no_resp", i), 64'(rvalid), 64'd0);
      end else begin
        read_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].d[8:0], vecs[i].exp);
      end
    end
    idle_cycle();
    check("rvalid_pulse_end", 64'(rvalid), 64'd0);
    check("leds_port", 64'(leds), 64'h35A);
    check("seven_seg_port", 64'(seven_seg), 64'h34_5678);

    // Back-to-back reads, one response per cycle in order.
    request = 1'b1; write = 1'b0; addr = 16'h0004; wdata = 32'h11;
    @(posedge clock); #1;
    addr = 16'h0008; wdata = 32'h122;
    check("b2b_0_rvalid", 64'(rvalid), 64'd1);
    check("b2b_0_rdata", 64'(rdata), 64'h35A);
    check("b2b_0_rtag", 64'(rtag), 64'h11);
    @(posedge clock); #1;
    request = 1'b0;
    check("b2b_1_rvalid", 64'(rvalid), 64'd1);
    check("b2b_1_rdata", 64'(rdata), 64'h2A5);
    check("b2b_1_rtag", 64'(rtag), 64'h122);
    idle_cycle();
    check("b2b_end_rvalid", 64'(rvalid), 64'd0);

    // Timer: write at cycle N, read request at N+3.
    do_write(16'h0020, 4'hF, 32'h0);
    idle_cycle();
    idle_cycle();
`ifdef HWREGS_TIMER_EN
    read_check("timer", 16'h0020, 9'h0C0, 32'd2);
`else
    read_check("timer", 16'h0020, 9'h0C0, 32'hDEAD_BEEF);
`endif

    // Single 0x55 frame, divider 4.
    byte_v = 8'h55;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       expv[i] = 1'b0;
      else if (i < 36) expv[i] = byte_v[(i - 4) / 4];
      else             expv[i] = 1'b1;
    end
    do_write(16'h0010, 4'b0001, 32'h0000_0055);
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("frame_start_latency", 64'(n), 64'd2);
    got[0] = uart_tx;
    for (int i = 1; i < 40; i++) begin
      @(negedge clock);
      got[i] = uart_tx;
    end
    check("frame_bits", 64'(got), 64'(expv));
    @(negedge clock);
    check("frame_idle_after", 64'(uart_tx), 64'd1);
    idle_cycle();
    read_check("stat_idle", 16'h0014, 9'h031, 32'h0);

    // Overflow: one byte occupies the shifter, then 17 pushes into 16 slots.
    do_write(16'h0010, 4'b0001, 32'h0000_00A3);
    repeat (3) idle_cycle();
    request = 1'b1; write = 1'b1; addr = 16'h0010; wmask = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      wdata = 32'(k);
      @(posedge clock); #1;
    end
    request = 1'b0; write = 1'b0;
    read_check("ovf_first", 16'h0010, 9'h040, 32'h8000_0000);
    read_check("ovf_second", 16'h0010, 9'h041, 32'h0000_0000);
    read_check("stat_busy", 16'h0014, 9'h042, 32'h0000_0001);
    repeat (30) idle_cycle();
    read_check("free_after_pop", 16'h0010, 9'h043, 32'h0000_0001);

    // Second frame (byte 0x00) is in its data bits: reset aborts it.
    reset = 1'b1;
    idle_cycle();
    check("abort_uart_tx", 64'(uart_tx), 64'd1);
    reset = 1'b0;
    read_check("abort_fifo_empty", 16'h0010, 9'h050, 32'h0000_0010);
    read_check("abort_stat", 16'h0014, 9'h051, 32'h0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) lows++;
    end
    check("abort_no_frame", 64'(lows), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwregs.md
# hwregs

Memory-mapped hardware register block sitting downstream of the aux-bus address decoder on the `hwregs_*` port (CPU addresses E000_0000–E000_FFFF; this block sees addr[15:0]). It holds the board LED and seven-segment registers, a switch input, a free-running cycle timer, and a UART transmitter fed by a byte FIFO. Read responses return one cycle after the request with the caller's tag, so the decoder can merge them onto the CPU return path.

## Interface
- CLOCK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; divider = CLOCK_HZ/BAUD, truncated.
- TX_FIFO_DEPTH, 16, UART TX FIFO entries; power of two, 2..256.

- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- hwregs_request  in  1  single-cycle request strobe.
- hwregs_write  in  1  1 = write, 0 = read.
- hwregs_addr  in  16  byte address; bits [1:0] ignored.
- hwregs_wmask  in  4  byte enables for writes.
- hwregs_wdata  in  32  write data; on reads, bits [8:0] carry the request tag.
- hwregs_rvalid  out  1  read response valid (one-cycle pulse).
- hwregs_rtag  out  9  tag of the responding read.
- hwregs_rdata  out  32  read data.
- switches  in  10  board switch inputs (synchronised externally).
- leds  out  10  LED register.
- seven_seg  out  24  six 4-bit hex digits for the display driver.
- uart_tx  out  1  serial output, idle high.

## Operation
- Register map (addr[15:2]*4):
  - 0x00 SEVEN_SEG: RW, bits [23:0]; wmask bytes 0–2 apply; upper bits read 0.
  - 0x04 LEDS: RW, bits [9:0]; wmask[0] → [7:0], wmask[1] → [9:8].
  - 0x08 SWITCHES: RO, zero-extended; writes ignored.
  - 0x10 UART_TX: write with wmask[0] pushes wdata[7:0]. Read returns free FIFO slots in [15:0] and the overflow flag in bit 31.
  - 0x14 UART_STAT: read bit 0 = transmitter busy (FIFO non-empty or shifter active). Reading clears nothing.
  - 0x20 TIMER: RO 32-bit cycle counter; any write clears it.
  - Any other address: reads return 0xDEADBEEF; writes are ignored.
- Reads: decode uses the request-cycle address. Response is registered; the tag is hwregs_wdata[8:0] from the request cycle.
- Writes never produce a response.
- TX FIFO:
  - A push while full drops the byte and sets the sticky overflow flag.
  - Fullness is evaluated before a same-cycle pop, so a push at full with a simultaneous pop is still dropped.
  - A read of UART_TX clears overflow; the read data shows the pre-clear value.
- UART serializer, 8N1, LSB first. FSM states:
  - IDLE: if FIFO non-empty, pop → START.
  - START: drive 0 for divider cycles → DATA.
  - DATA: 8 bits, each held divider cycles; bit counter 0..7 → STOP.
  - STOP: drive 1 for divider cycles → IDLE.
  - IDLE-to-START adds no extra gap cycle beyond the pop cycle.
- TIMER: increments every cycle and wraps 0xFFFFFFFF → 0. A write loads 0 (counter reads 0 the next cycle, then increments).

## Timing
- Read latency: request at cycle N → rvalid=1 at N+1 for exactly one cycle. Back-to-back reads are supported, one response per cycle in order.
- Write effects are visible to a read issued the following cycle.
- TIMER read returns the value held during the request cycle.
- Reset values:
  - Outputs: rvalid 0, rtag 0, rdata 0, leds 0, seven_seg 0, uart_tx 1.
  - Internal: FIFO empty, overflow 0, timer 0, FSM IDLE.
- Reset asserted mid-frame aborts the frame: uart_tx is 1 the cycle after reset and FIFO contents are discarded.
- A request during reset is ignored; no response is produced.

## Configuration
- HWREGS_TIMER_EN:
  - Defined: TIMER register present as described.
  - Undefined: counter not built; 0x20 behaves as an unmapped address (read 0xDEADBEEF, write ignored).

## Test plan
- Write LEDS 0x3FF with wmask 0b0001, then read tag 0x1A5 → rvalid one cycle after the read, rdata 0x000000FF, rtag 0x1A5.
- Write UART_TX 0x55 (divider = 4 in test config) → uart_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles; UART_STAT bit 0 = 0 afterwards.
- Push 17 bytes with depth 16 while the shifter is stalled in its first frame → UART_TX read = 0x80000000 | 0 free (after one pop: 0x80000000 | 1); a second read shows bit 31 clear.
- Write TIMER at cycle N; read at N+3 → rdata 2.
- Read 0x0100 with tag 0x003 → rdata 0xDEADBEEF, rtag 0x003.
- Assert reset during the DATA state → uart_tx=1 next cycle, FIFO empty, no further frame transmitted.
